// File: rtl/fifo_wr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_rr_arbiter
//
// Round-robin arbiter sharing the single write port of a dual-clock FWFT FIFO
// between NUM_REQ valid/ready streaming requesters. Runs entirely in the FIFO
// write-clock domain. A grant covers a contiguous burst of words that ends on
// req_last, after MAX_BURST words, or when the owner drops req_vld. Words
// are accepted only while the FIFO is neither almost-full nor full, and are
// presented to the FIFO one cycle after acceptance.
//
// One word can be in flight, so the FIFO almost-full threshold must be set to
// at most DEPTH-2 for fifo_wren never to coincide with fifo_full.
//
// Ports:
//   clk         in   write-side clock (FIFO wrclk)
//   clk_rst_n   in   synchronous reset, active-low
//   req_vld     in   [NUM_REQ]        per-requester word valid
//   req_data    in   [NUM_REQ*WIDTH]  requester i at [i*WIDTH +: WIDTH]
//   req_last    in   [NUM_REQ]        last word of a requester's burst
//   req_rdy     out  [NUM_REQ]        per-requester accept (combinational)
//   fifo_wren   out  FIFO write enable (registered)
//   fifo_wdata  out  [WIDTH] FIFO write data (registered)
//   fifo_afull  in   FIFO almost-full
//   fifo_full   in   FIFO full
//   grant_id    out  [ID_W] current or last granted requester
//   busy        out  high while a burst is granted
//
// Optional build macro FIFO_WR_ARB_STATS_EN adds:
//   stat_clr    in   synchronous clear of all word counters (beats a transfer)
//   stat_words  out  [NUM_REQ*32] per-requester saturating accepted-word count
// ---------------------------------------------------------------------------
module fifo_wr_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       clk_rst_n,
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic                       fifo_wren,
  output logic [WIDTH-1:0]           fifo_wdata,
  input  logic                       fifo_afull,
  input  logic                       fifo_full,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [NUM_REQ*32-1:0]      stat_words
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_grant_id;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic               r_vld_p1;
  logic [WIDTH-1:0]   r_data_p1;

  logic               w_space_ok;
  logic [NUM_REQ-1:0] w_req_rdy;
  logic               w_gnt_vld;
  logic               w_gnt_last;
  logic [WIDTH-1:0]   w_gnt_data;
  logic               w_xfer;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_hit_max;
  logic               w_release;
  logic               w_any_vld;
  logic               w_found;
  logic [ID_W-1:0]    w_pick;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) return '0;
    return id + ID_W'(1);
  endfunction

  assign w_space_ok = ~fifo_afull & ~fifo_full;

  // Ready and owner-side mux: only the granted requester can see ready.
  always_comb begin
    w_req_rdy  = '0;
    w_gnt_vld  = 1'b0;
    w_gnt_last = 1'b0;
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == ID_W'(i)) begin
        w_req_rdy[i] = (r_state == S_BURST) & w_space_ok;
        w_gnt_vld    = req_vld[i];
        w_gnt_last   = req_last[i];
        w_gnt_data   = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_xfer    = (r_state == S_BURST) & w_gnt_vld & w_space_ok;
  assign w_cnt_nxt = r_burst_cnt + CNT_W'(1);
  assign w_hit_max = (w_cnt_nxt == CNT_W'(MAX_BURST));
  // Losing req_vld ends the burst even while back-pressured.
  assign w_release = (w_xfer & (w_gnt_last | w_hit_max)) | ~w_gnt_vld;
  assign w_any_vld = |req_vld;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req_vld[idx]) begin
        w_pick  = ID_W'(idx);
        w_found = 1'b1;
      end
    end
  end

  // Stage p0 -> p1: arbitration state and the accepted word register.
  always_ff @(posedge clk) begin
    if (!clk_rst_n) begin
      r_state     <= S_IDLE;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_vld_p1    <= 1'b0;
      r_data_p1   <= '0;
    end else begin
      r_vld_p1 <= w_xfer;
      if (w_xfer) r_data_p1 <= w_gnt_data;
      case (r_state)
        S_IDLE: begin
          if (w_any_vld) begin
            r_grant_id  <= w_pick;
            r_burst_cnt <= '0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_xfer) r_burst_cnt <= w_cnt_nxt;
          if (w_release) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= next_id(r_grant_id);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_rdy    = w_req_rdy;
  assign fifo_wren  = r_vld_p1;
  assign fifo_wdata = r_data_p1;
  assign grant_id   = r_grant_id;
  assign busy       = (r_state == S_BURST);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [31:0] r_stat [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!clk_rst_n || stat_clr) begin
        r_stat[i] <= '0;
      end else if (w_xfer && (r_grant_id == ID_W'(i)) &&
                   (r_stat[i] != 32'hFFFF_FFFF)) begin
        r_stat[i] <= r_stat[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_words[g*32 +: 32] = r_stat[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for fifo_wr_rr_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=16).
// A behavioural model of the arbitration rules runs on the falling edge and
// predicts ready, busy, grant and the write port each cycle; directed
// scenarios add timing and ordering checks, then a long random phase follows.
// ---------------------------------------------------------------------------
module tb_fifo_wr_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            clk_rst_n;
  logic [N-1:0]    req_vld, req_last, req_rdy;
  logic [N*W-1:0]  req_data;
  logic            fifo_wren;
  logic [W-1:0]    fifo_wdata;
  logic            fifo_afull, fifo_full;
  logic [IW-1:0]   grant_id;
  logic            busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic            stat_clr;
  logic [N*32-1:0] stat_words;
`endif

  always #5 clk = ~clk;

  fifo_wr_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .clk_rst_n(clk_rst_n),
    .req_vld(req_vld), .req_data(req_data), .req_last(req_last), .req_rdy(req_rdy),
    .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata),
    .fifo_afull(fifo_afull), .fifo_full(fifo_full),
    .grant_id(grant_id), .busy(busy)
`ifdef FIFO_WR_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_words(stat_words)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how many words so far, where the
  // round-robin search starts next, and what the FIFO should see next cycle.
  bit          chk_en = 1'b0;
  bit          m_busy;
  int          m_owner, m_cnt, m_ptr;
  bit          m_wren;
  logic [W-1:0] m_wdata;
  logic [N-1:0] exp_rdy;
  bit          m_xfer, m_found;
  int          obs_acc [N];
  int          n_wren_obs = 0;

  initial begin
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_wren = 0; m_wdata = '0;
    for (int i = 0; i < N; i++) obs_acc[i] = 0;
  end

  always @(negedge clk) begin
    exp_rdy = (m_busy && !fifo_afull && !fifo_full) ? (N'(1) << m_owner) : '0;
    if (chk_en) begin
      check_eq("req_rdy",    req_rdy,    exp_rdy);
      check_eq("busy",       busy,       m_busy);
      check_eq("grant_id",   grant_id,   m_owner);
      check_eq("fifo_wren",  fifo_wren,  m_wren);
      check_eq("fifo_wdata", fifo_wdata, m_wdata);
    end
    for (int i = 0; i < N; i++)
      if (req_vld[i] && req_rdy[i]) obs_acc[i]++;
    if (fifo_wren === 1'b1) n_wren_obs++;

    if (!clk_rst_n) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_wren = 0; m_wdata = '0;
    end else if (!m_busy) begin
      m_wren = 0;
      if (|req_vld) begin
        m_found = 0;
        for (int k = 0; k < N; k++) begin
          if (!m_found && req_vld[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_found = 1;
          end
        end
        m_cnt  = 0;
        m_busy = 1;
      end
    end else begin
      m_xfer = req_vld[m_owner] && exp_rdy[m_owner];
      m_wren = m_xfer;
      if (m_xfer) begin
        m_wdata = req_data[m_owner*W +: W];
        m_cnt++;
      end
      if ((m_xfer && (req_last[m_owner] || m_cnt == MB)) || !req_vld[m_owner]) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    clk_rst_n  = 1'b0;
    req_vld    = '0;
    req_last   = '0;
    fifo_afull = 1'b0;
    fifo_full  = 1'b0;
    step();
    step();
    clk_rst_n  = 1'b1;
  endtask

  int base, base_w, tot0, ng;
  int order [8];
  bit pb;

  initial begin
    req_data = '0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    reset_dut();
    chk_en = 1'b1;

    // Idle after reset: model checks every cycle.
    repeat (20) step();

    // Single requester 2, five words 0x10..0x14, last on the fifth.
    base = obs_acc[2];
    req_vld = 4'b0100;
    for (int t = 0; t < 40 && (obs_acc[2] - base) < 5; t++) begin
      req_data[2*W +: W] = 8'h10 + 8'(obs_acc[2] - base);
      req_last[2] = ((obs_acc[2] - base) == 4);
      step();
    end
    req_vld = '0; req_last = '0;
    check_eq("s2_words", obs_acc[2] - base, 5);
    check_eq("s2_last_data", fifo_wdata, 8'h14);
    check_eq("s2_busy_fall", busy, 0);
    step();

    // All four continuously valid: two full rounds in 136 clocks.
    reset_dut();
    req_vld = 4'hF;
    tot0 = obs_acc[0] + obs_acc[1] + obs_acc[2] + obs_acc[3];
    ng = 0; pb = 0;
    for (int t = 0; t < 136; t++) begin
      for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'($urandom);
      step();
      if (busy && !pb && ng < 8) begin
        order[ng] = grant_id;
        ng++;
      end
      pb = busy;
    end
    check_eq("s3_words", obs_acc[0] + obs_acc[1] + obs_acc[2] + obs_acc[3] - tot0, 128);
    check_eq("s3_bursts", ng, 8);
    for (int j = 0; j < 8; j++) check_eq("s3_order", order[j], j % N);
    req_vld = '0;
    step();
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) check_eq("stat_words", stat_words[i*32 +: 32], 32);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    for (int i = 0; i < N; i++) check_eq("stat_clr", stat_words[i*32 +: 32], 0);
`endif

    // Requester 1 bursting, almost-full held for 7 clocks after word 5.
    reset_dut();
    req_vld = 4'b0010;
    base = obs_acc[1];
    for (int t = 0; t < 40 && (obs_acc[1] - base) < 5; t++) step();
    fifo_afull = 1'b1;
    base_w = n_wren_obs;
    tot0 = obs_acc[1];
    repeat (7) step();
    fifo_afull = 1'b0;
    check_eq("s4_hold_acc", obs_acc[1] - tot0, 0);
    check_eq("s4_hold_wren", n_wren_obs - base_w, 1);
    check_eq("s4_hold_grant", grant_id, 1);
    for (int t = 0; t < 40 && (obs_acc[1] - base) < 16; t++) step();
    check_eq("s4_words", obs_acc[1] - base, 16);
    check_eq("s4_release", busy, 0);
    req_vld = '0;
    step();

    // Reset on the third word of a burst; next grant to lowest valid index.
    reset_dut();
    req_vld = 4'b1010;
    base = obs_acc[1];
    for (int t = 0; t < 40 && (obs_acc[1] - base) < 2; t++) step();
    clk_rst_n = 1'b0;
    step();
    clk_rst_n = 1'b1;
    check_eq("s5_wren_drop", fifo_wren, 0);
    check_eq("s5_idle", busy, 0);
    step();
    check_eq("s5_regrant_busy", busy, 1);
    check_eq("s5_regrant_id", grant_id, 1);

    // Random traffic, back-pressure and occasional resets.
    for (int t = 0; t < 3000; t++) begin
      req_vld    = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_data[i*W +: W] = 8'($urandom);
        req_last[i] = ($urandom_range(0, 7) == 0);
      end
      fifo_afull = ($urandom_range(0, 5) == 0);
      fifo_full  = fifo_afull && ($urandom_range(0, 1) == 0);
      clk_rst_n  = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
